axi_aw_scheduler: RTL and testbench

AXI_AW_SCHEDULER -- requirements
Module: axi_aw_scheduler

---
 rtl/axi_sched_pkg.sv | 21 ++
 rtl/axi_order_fifo.sv | 67 ++++++
 rtl/axi_aw_scheduler.sv | 129 ++++++++++++
 tb/tb_axi_aw_scheduler.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/axi_sched_pkg.sv
// Shared constants, FSM encoding and helpers for the AXI AW scheduler.
package axi_sched_pkg;

    localparam int NUM_MASTERS = 4;
    localparam int IDX_W       = 2;
    localparam int CNT_W       = 5;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } aw_state_e;

    // Master index to one-hot select vector.
    function automatic logic [NUM_MASTERS-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_MASTERS-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/axi_order_fifo.sv
// Write-order FIFO: records which master won each AW handshake so W data
// is granted in the same order. Push on full and pop on empty are ignored.
module axi_order_fifo
    import axi_sched_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [IDX_W-1:0] push_idx,
    input  logic             pop,
    output logic [IDX_W-1:0] head_idx,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [IDX_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign head_idx = mem_q[rd_ptr_q];
    assign count    = count_q;

    // Next pointers and occupancy; pointers wrap naturally since depth is a power of 2.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset empties the queue.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_idx;
    end

endmodule

// File: rtl/axi_aw_scheduler.sv
// AXI write-address arbiter for four masters with in-order W-data steering.
// AW grants are round-robin and registered; each accepted AW queues the
// winner so the W channel is handed to masters in address order.
module axi_aw_scheduler
    import axi_sched_pkg::*;
#(
    parameter int OUTSTANDING_DEPTH = 4,
    parameter int NUM_MASTERS       = 4
) (
    input  logic                   ACLK,
    input  logic                   ARESET,
    input  logic [NUM_MASTERS-1:0] AW_REQ_MI,
    output logic [NUM_MASTERS-1:0] AW_GNT_MI,
    output logic                   AWVALID_S,
    input  logic                   AWREADY_S,
    output logic [NUM_MASTERS-1:0] W_MASGNT_MI,
    input  logic                   WVALID_SEL,
    input  logic                   WLAST_SEL,
    input  logic                   WREADY_S,
    output logic [CNT_W-1:0]       WR_COUNT,
    output logic                   W_ORDER_ERR
);

    aw_state_e              state_q;
    logic [NUM_MASTERS-1:0] gnt_q;
    logic                   awvalid_q;
    logic [IDX_W-1:0]       winner_q;
    logic [IDX_W-1:0]       last_winner_q;
    logic                   err_q, err_d;

    logic [IDX_W-1:0]       rr_pick;
    logic                   rr_found;
    logic                   can_grant;
    logic                   aw_hs;
    logic                   wlast_hs;
    logic                   fifo_pop;
    logic [IDX_W-1:0]       fifo_head;
    logic [CNT_W-1:0]       fifo_count;
    logic                   fifo_empty;
    logic                   fifo_full;

    assign aw_hs     = (state_q == ST_GRANT) & awvalid_q & AWREADY_S;
    assign wlast_hs  = WVALID_SEL & WREADY_S & WLAST_SEL;
    assign fifo_pop  = wlast_hs & ~fifo_empty;
    // A grant is only started with room left, so the in-flight AW always fits.
    assign can_grant = (|AW_REQ_MI) && (fifo_count < CNT_W'(OUTSTANDING_DEPTH));

    // Round-robin search starting one past the last winner.
    always_comb begin
        logic [IDX_W-1:0] cand;
        rr_pick  = last_winner_q + 1'b1;
        rr_found = 1'b0;
        cand     = '0;
        for (int i = 0; i < 4; i++) begin
            cand = last_winner_q + IDX_W'(i + 1);
            if (!rr_found && AW_REQ_MI[cand]) begin
                rr_pick  = cand;
                rr_found = 1'b1;
            end
        end
    end

    // AW FSM: grant is latched on entry to GRANT and held until the slave accepts.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q       <= ST_IDLE;
            gnt_q         <= '0;
            awvalid_q     <= 1'b0;
            winner_q      <= '0;
            last_winner_q <= 2'd3;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (can_grant) begin
                        state_q   <= ST_GRANT;
                        gnt_q     <= idx_to_onehot(rr_pick);
                        awvalid_q <= 1'b1;
                        winner_q  <= rr_pick;
                    end
                end
                ST_GRANT: begin
                    if (aw_hs) begin
                        state_q       <= ST_IDLE;
                        gnt_q         <= '0;
                        awvalid_q     <= 1'b0;
                        last_winner_q <= winner_q;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    gnt_q     <= '0;
                    awvalid_q <= 1'b0;
                end
            endcase
        end
    end

    // A WLAST with nothing queued means the W stream is out of step with AW.
    always_comb begin
        err_d = wlast_hs & fifo_empty;
    end

    // Registered one-cycle order-error pulse.
    always_ff @(posedge ACLK) begin
        if (ARESET) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    axi_order_fifo #(
        .DEPTH (OUTSTANDING_DEPTH)
    ) u_order_fifo (
        .clk      (ACLK),
        .rst      (ARESET),
        .push     (aw_hs),
        .push_idx (winner_q),
        .pop      (fifo_pop),
        .head_idx (fifo_head),
        .count    (fifo_count),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    assign AW_GNT_MI   = gnt_q;
    assign AWVALID_S   = awvalid_q;
    assign W_MASGNT_MI = fifo_empty ? '0 : idx_to_onehot(fifo_head);
    assign WR_COUNT    = fifo_count;
    assign W_ORDER_ERR = err_q;

endmodule

// File: tb/tb_axi_aw_scheduler.sv
// Directed bench for axi_aw_scheduler: per-cycle vector table plus
// hand-written sequences for the full-queue and reset-during-grant cases.
module tb_axi_aw_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       awready;
    logic [3:0] gnt;
    logic       awvalid;
    logic [3:0] wgnt;
    logic       wvalid;
    logic       wlast;
    logic       wready;
    logic [4:0] wr_count;
    logic       order_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi_aw_scheduler #(
        .OUTSTANDING_DEPTH (4),
        .NUM_MASTERS       (4)
    ) dut (
        .ACLK        (clk),
        .ARESET      (rst),
        .AW_REQ_MI   (req),
        .AW_GNT_MI   (gnt),
        .AWVALID_S   (awvalid),
        .AWREADY_S   (awready),
        .W_MASGNT_MI (wgnt),
        .WVALID_SEL  (wvalid),
        .WLAST_SEL   (wlast),
        .WREADY_S    (wready),
        .WR_COUNT    (wr_count),
        .W_ORDER_ERR (order_err)
    );

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       ar;
        logic       wv;
        logic       wl;
        logic       wr;
        logic [3:0] e_gnt;
        logic       e_av;
        logic [3:0] e_wg;
        logic [4:0] e_cnt;
        logic       e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic ar,
                                input logic wv, input logic wl, input logic wr,
                                input logic [3:0] g, input logic av, input logic [3:0] wg,
                                input logic [4:0] c, input logic e);
        vec_t v;
        v.rst = r;  v.req = rq; v.ar = ar; v.wv = wv; v.wl = wl; v.wr = wr;
        v.e_gnt = g; v.e_av = av; v.e_wg = wg; v.e_cnt = c; v.e_err = e;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] rq, input logic ar,
                         input logic wv, input logic wl, input logic wr);
        rst = r; req = rq; awready = ar; wvalid = wv; wlast = wl; wready = wr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [3:0] g, input logic av,
                           input logic [3:0] wg, input logic [4:0] c, input logic e);
        chk({tag, ".aw_gnt"},   32'(gnt),       32'(g));
        chk({tag, ".awvalid"},  32'(awvalid),   32'(av));
        chk({tag, ".w_gnt"},    32'(wgnt),      32'(wg));
        chk({tag, ".wr_count"}, 32'(wr_count),  32'(c));
        chk({tag, ".order_err"},32'(order_err), 32'(e));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        drive(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);

        //            rst req      ar  wv  wl  wr    gnt      av  wgnt     cnt err
        // reset state
        vecs.push_back(mk(1, 4'b0000, 0, 0, 0, 0,  4'b0000, 0, 4'b0000, 0, 0));
        // 0101 held with AWREADY=1: grants 0,2,0 with an idle cycle between handshakes
        vecs.push_back(mk(0, 4'b0101, 1, 0, 0, 0,  4'b0001, 1, 4'b0000, 0, 0));
        vecs.push_back(mk(0, 4'b0101, 1, 0, 0, 0,  4'b0000, 0, 4'b0001, 1, 0));
        vecs.push_back(mk(0, 4'b0101, 1, 0, 0, 0,  4'b0100, 1, 4'b0001, 1, 0));
        vecs.push_back(mk(0, 4'b0101, 1, 0, 0, 0,  4'b0000, 0, 4'b0001, 2, 0));
        vecs.push_back(mk(0, 4'b0101, 1, 0, 0, 0,  4'b0001, 1, 4'b0001, 2, 0));
        vecs.push_back(mk(0, 4'b0000, 1, 0, 0, 0,  4'b0000, 0, 4'b0001, 3, 0));
        // drain queue [0,2,0]; non-last beat and stalled WLAST leave it alone
        vecs.push_back(mk(0, 4'b0000, 0, 1, 1, 1,  4'b0000, 0, 4'b0100, 2, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 1, 1, 1,  4'b0000, 0, 4'b0001, 1, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 1, 0, 1,  4'b0000, 0, 4'b0001, 1, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 1, 1, 0,  4'b0000, 0, 4'b0001, 1, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 1, 1, 1,  4'b0000, 0, 4'b0000, 0, 0));
        // WLAST with empty queue: one-cycle error pulse, count stays 0
        vecs.push_back(mk(0, 4'b0000, 0, 1, 1, 1,  4'b0000, 0, 4'b0000, 0, 1));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 0,  4'b0000, 0, 4'b0000, 0, 0));
        // master 2 then 1; grant held while AWREADY low even after request drops
        vecs.push_back(mk(0, 4'b0100, 0, 0, 0, 0,  4'b0100, 1, 4'b0000, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 0,  4'b0100, 1, 4'b0000, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 1, 0, 0, 0,  4'b0000, 0, 4'b0100, 1, 0));
        vecs.push_back(mk(0, 4'b0010, 1, 0, 0, 0,  4'b0010, 1, 4'b0100, 1, 0));
        vecs.push_back(mk(0, 4'b0000, 1, 0, 0, 0,  4'b0000, 0, 4'b0100, 2, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 1, 1, 1,  4'b0000, 0, 4'b0010, 1, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 1, 1, 1,  4'b0000, 0, 4'b0000, 0, 0));
        // build queue [0,3], then push 2 and pop 0 in the same cycle
        vecs.push_back(mk(0, 4'b0001, 1, 0, 0, 0,  4'b0001, 1, 4'b0000, 0, 0));
        vecs.push_back(mk(0, 4'b1000, 1, 0, 0, 0,  4'b0000, 0, 4'b0001, 1, 0));
        vecs.push_back(mk(0, 4'b1000, 1, 0, 0, 0,  4'b1000, 1, 4'b0001, 1, 0));
        vecs.push_back(mk(0, 4'b0100, 1, 0, 0, 0,  4'b0000, 0, 4'b0001, 2, 0));
        vecs.push_back(mk(0, 4'b0100, 1, 0, 0, 0,  4'b0100, 1, 4'b0001, 2, 0));
        vecs.push_back(mk(0, 4'b0000, 1, 1, 1, 1,  4'b0000, 0, 4'b1000, 2, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 1, 1, 1,  4'b0000, 0, 4'b0100, 1, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 1, 1, 1,  4'b0000, 0, 4'b0000, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].req, vecs[i].ar, vecs[i].wv, vecs[i].wl, vecs[i].wr);
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].e_gnt, vecs[i].e_av,
                    vecs[i].e_wg, vecs[i].e_cnt, vecs[i].e_err);
        end

        // Full queue: four handshakes from master 0, then requests are blocked
        drive(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (8) tick();
        chk_all("full.filled", 4'b0000, 1'b0, 4'b0001, 5'd4, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all($sformatf("full.blocked%0d", i), 4'b0000, 1'b0, 4'b0001, 5'd4, 1'b0);
        end
        drive(1'b0, 4'b0001, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        chk_all("full.pop", 4'b0000, 1'b0, 4'b0001, 5'd3, 1'b0);
        drive(1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_all("full.regrant", 4'b0001, 1'b1, 4'b0001, 5'd3, 1'b0);

        // Reset while in GRANT with three entries queued
        drive(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_all("rstgrant.held", 4'b0001, 1'b1, 4'b0001, 5'd3, 1'b0);
        drive(1'b1, 4'b0100, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        chk_all("rstgrant.cleared", 4'b0000, 1'b0, 4'b0000, 5'd0, 1'b0);
        drive(1'b0, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_all("rstgrant.master0", 4'b0001, 1'b1, 4'b0000, 5'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
